// File: rtl/sync_rr_arbiter.sv
// sync_rr_arbiter: round-robin arbiter for N requesters whose request levels
// may be asynchronous to clk. Each request is double-flop synchronized, then a
// two-state arbiter hands out a one-hot, level-held grant. An optional hold
// timeout revokes a stuck grant and locks the offender out until it drops its
// request.
module sync_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255,
  parameter int IDW     = (N > 1) ? $clog2(N) : 1,
  parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_async,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout_pulse,
  output logic [N-1:0]   locked
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit             TO_EN    = (TIMEOUT > 0);
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  // First set bit of e, searching upward from p and wrapping modulo N.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] e,
                                             input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic           found;
    int             j;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(p) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!found && e[j]) begin
        w     = IDW'(j);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  logic [N-1:0]   sync1_r;
  logic [N-1:0]   sync2_r;
  logic [N-1:0]   req_s;
  state_t         state_r;
  state_t         state_nxt_s;
  logic [IDW-1:0] ptr_r;
  logic [CW-1:0]  cnt_r;

  logic [N-1:0]   elig_s;
  logic [IDW-1:0] winner_s;
  logic           release_s;
  logic           revoke_s;
  logic [IDW-1:0] next_ptr_s;

  logic [N-1:0]   gnt_nxt_s;
  logic           valid_nxt_s;
  logic [IDW-1:0] id_nxt_s;
  logic           pulse_nxt_s;
  logic [N-1:0]   locked_nxt_s;
  logic [IDW-1:0] ptr_nxt_s;
  logic [CW-1:0]  cnt_nxt_s;

  assign req_s = sync2_r;

  // Two-flop synchronizer; the only logic that samples req_async.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= req_async;
      sync2_r <= sync1_r;
    end
  end

  // Shared decode: eligible set, round-robin winner and grant-end conditions.
  always_comb begin
    elig_s     = req_s & ~locked;
    winner_s   = rr_pick(elig_s, ptr_r);
    release_s  = (state_r == GRANT) && !req_s[gnt_id];
    revoke_s   = (state_r == GRANT) && req_s[gnt_id] && TO_EN && (cnt_r == CNT_LAST);
    if (gnt_id == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_id + IDW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: arbitrate only from IDLE, leave GRANT on release or revoke.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (elig_s != '0) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s || revoke_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: next values of grant, pointer, hold counter and lockout flags.
  always_comb begin
    gnt_nxt_s    = gnt;
    valid_nxt_s  = gnt_valid;
    id_nxt_s     = gnt_id;
    pulse_nxt_s  = 1'b0;
    ptr_nxt_s    = ptr_r;
    cnt_nxt_s    = cnt_r;
    locked_nxt_s = locked & req_s;
    case (state_r)
      IDLE: begin
        if (elig_s != '0) begin
          gnt_nxt_s           = '0;
          gnt_nxt_s[winner_s] = 1'b1;
          valid_nxt_s         = 1'b1;
          id_nxt_s            = winner_s;
          cnt_nxt_s           = '0;
        end else begin
          gnt_nxt_s   = '0;
          valid_nxt_s = 1'b0;
          id_nxt_s    = '0;
        end
      end
      GRANT: begin
        if (release_s || revoke_s) begin
          gnt_nxt_s   = '0;
          valid_nxt_s = 1'b0;
          id_nxt_s    = '0;
          ptr_nxt_s   = next_ptr_s;
          cnt_nxt_s   = '0;
          if (revoke_s) begin
            pulse_nxt_s          = 1'b1;
            locked_nxt_s[gnt_id] = 1'b1;
          end else begin
            pulse_nxt_s = 1'b0;
          end
        end else if (TO_EN) begin
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        gnt_nxt_s   = '0;
        valid_nxt_s = 1'b0;
        id_nxt_s    = '0;
      end
    endcase
  end

  // Registered outputs plus round-robin pointer and hold counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt           <= '0;
      gnt_valid     <= 1'b0;
      gnt_id        <= '0;
      timeout_pulse <= 1'b0;
      locked        <= '0;
      ptr_r         <= '0;
      cnt_r         <= '0;
    end else begin
      gnt           <= gnt_nxt_s;
      gnt_valid     <= valid_nxt_s;
      gnt_id        <= id_nxt_s;
      timeout_pulse <= pulse_nxt_s;
      locked        <= locked_nxt_s;
      ptr_r         <= ptr_nxt_s;
      cnt_r         <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Bench for sync_rr_arbiter: directed scenarios on a TIMEOUT=8 instance and a
// randomized run on a TIMEOUT=16 instance compared against a behavioural model.
module tb_sync_rr_arbiter;

  logic       clk = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic       reset8, reset16;
  logic [3:0] req8, req16;
  logic [3:0] gnt8, gnt16, locked8, locked16;
  logic       valid8, valid16, pulse8, pulse16;
  logic [1:0] id8, id16;

  sync_rr_arbiter #(.N(4), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset8), .req_async(req8), .gnt(gnt8), .gnt_valid(valid8),
    .gnt_id(id8), .timeout_pulse(pulse8), .locked(locked8)
  );

  sync_rr_arbiter #(.N(4), .TIMEOUT(16)) dut16 (
    .clk(clk), .reset(reset16), .req_async(req16), .gnt(gnt16), .gnt_valid(valid16),
    .gnt_id(id16), .timeout_pulse(pulse16), .locked(locked16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset8();
    reset8 = 1'b0;
    req8   = 4'b0000;
    tick();
    tick();
    reset8 = 1'b1;
  endtask

  task automatic wait_grant8(output int n);
    n = 0;
    while (!valid8 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_release8(output int n);
    n = 0;
    while (valid8 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset8  = 1'b1;
    reset16 = 1'b1;
    req8    = 4'b0000;
    req16   = 4'b0000;
    #1;
    reset8  = 1'b0;
    reset16 = 1'b0;
    #1;
    checks++;
    if ({gnt8, valid8, id8, pulse8, locked8} !== 12'd0) begin
      failures++;
      $display("FAIL reset8: got gnt=%b v=%b id=%0d p=%b lk=%b want all 0", gnt8, valid8, id8, pulse8, locked8);
    end
    checks++;
    if ({gnt16, valid16, id16, pulse16, locked16} !== 12'd0) begin
      failures++;
      $display("FAIL reset16: got gnt=%b v=%b id=%0d p=%b lk=%b want all 0", gnt16, valid16, id16, pulse16, locked16);
    end
    tick();
    tick();
    reset8  = 1'b1;
    reset16 = 1'b1;
  endtask

  task automatic test_single();
    apply_reset8();
    req8 = 4'b0100;
    tick();
    tick();
    checks++;
    if (gnt8 !== 4'b0000) begin
      failures++;
      $display("FAIL single_latency: got gnt=%b at edge 2 want 0000", gnt8);
    end
    tick();
    checks++;
    if (gnt8 !== 4'b0100 || id8 !== 2'd2 || valid8 !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: got gnt=%b id=%0d v=%b want 0100/2/1", gnt8, id8, valid8);
    end
    req8 = 4'b0000;
    tick();
    tick();
    checks++;
    if (gnt8 !== 4'b0100) begin
      failures++;
      $display("FAIL single_hold: got gnt=%b want 0100", gnt8);
    end
    tick();
    checks++;
    if (gnt8 !== 4'b0000 || valid8 !== 1'b0 || id8 !== 2'd0 || pulse8 !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got gnt=%b v=%b id=%0d p=%b want 0000/0/0/0", gnt8, valid8, id8, pulse8);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_id;
    int owner;
    apply_reset8();
    req8 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      wait_grant8(n);
      checks++;
      if (n >= 40 || (k > 0 && n < 1)) begin
        failures++;
        $display("FAIL rr_gap_%0d: got %0d idle cycles want 1..39", k, n);
      end
      checks++;
      if (gnt8 !== (4'b0001 << exp_id) || int'(id8) != exp_id) begin
        failures++;
        $display("FAIL rr_order_%0d: got gnt=%b id=%0d want id %0d", k, gnt8, id8, exp_id);
      end
      owner = int'(id8);
      req8[owner] = 1'b0;
      tick();
      req8[owner] = 1'b1;
      wait_release8(n);
    end
    req8 = 4'b0000;
    wait_release8(n);
  endtask

  task automatic test_timeout();
    int n;
    int len;
    int extra;
    apply_reset8();
    req8 = 4'b0001;
    wait_grant8(n);
    len = 0;
    while (gnt8[0] && len < 40) begin
      len++;
      tick();
    end
    checks++;
    if (len != 8) begin
      failures++;
      $display("FAIL to_length: got %0d cycles want 8", len);
    end
    checks++;
    if (pulse8 !== 1'b1 || locked8 !== 4'b0001) begin
      failures++;
      $display("FAIL to_revoke: got pulse=%b locked=%b want 1/0001", pulse8, locked8);
    end
    tick();
    checks++;
    if (pulse8 !== 1'b0) begin
      failures++;
      $display("FAIL to_pulse_width: got pulse=%b want 0", pulse8);
    end
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (valid8) extra++;
      tick();
    end
    checks++;
    if (extra != 0 || locked8 !== 4'b0001) begin
      failures++;
      $display("FAIL to_lockout: got %0d grant cycles locked=%b want 0/0001", extra, locked8);
    end
    req8 = 4'b0000;
    tick();
    tick();
    tick();
    checks++;
    if (locked8 !== 4'b0000) begin
      failures++;
      $display("FAIL to_unlock: got locked=%b want 0000", locked8);
    end
    req8 = 4'b0001;
    wait_grant8(n);
    checks++;
    if (n >= 40 || gnt8 !== 4'b0001) begin
      failures++;
      $display("FAIL to_regrant: got gnt=%b after %0d cycles want 0001", gnt8, n);
    end
    req8 = 4'b0000;
    wait_release8(n);
  endtask

  task automatic test_release_race();
    int n;
    apply_reset8();
    req8 = 4'b0001;
    wait_grant8(n);
    repeat (5) tick();
    req8 = 4'b0000;
    tick();
    tick();
    checks++;
    if (gnt8 !== 4'b0001) begin
      failures++;
      $display("FAIL race_hold: got gnt=%b want 0001", gnt8);
    end
    tick();
    checks++;
    if (gnt8 !== 4'b0000 || pulse8 !== 1'b0 || locked8 !== 4'b0000) begin
      failures++;
      $display("FAIL race_release: got gnt=%b pulse=%b locked=%b want 0000/0/0000", gnt8, pulse8, locked8);
    end
    tick();
    checks++;
    if (pulse8 !== 1'b0 || locked8 !== 4'b0000) begin
      failures++;
      $display("FAIL race_after: got pulse=%b locked=%b want 0/0000", pulse8, locked8);
    end
  endtask

  task automatic test_reset_mid_grant();
    int n;
    apply_reset8();
    req8 = 4'b0010;
    wait_grant8(n);
    tick();
    reset8 = 1'b0;
    #1;
    checks++;
    if (gnt8 !== 4'b0000 || valid8 !== 1'b0 || id8 !== 2'd0) begin
      failures++;
      $display("FAIL mid_async_clear: got gnt=%b v=%b id=%0d want 0000/0/0", gnt8, valid8, id8);
    end
    #2;
    reset8 = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt8 !== 4'b0000) begin
      failures++;
      $display("FAIL mid_latency: got gnt=%b want 0000", gnt8);
    end
    tick();
    checks++;
    if (gnt8 !== 4'b0010) begin
      failures++;
      $display("FAIL mid_regrant: got gnt=%b want 0010", gnt8);
    end
    // Leave ptr at 1, hold a grant on 1, then reset with both 0 and 1 asking.
    apply_reset8();
    req8 = 4'b0001;
    wait_grant8(n);
    req8 = 4'b0000;
    wait_release8(n);
    req8 = 4'b0010;
    wait_grant8(n);
    tick();
    reset8 = 1'b0;
    req8   = 4'b0011;
    #1;
    checks++;
    if (gnt8 !== 4'b0000) begin
      failures++;
      $display("FAIL mid_clear2: got gnt=%b want 0000", gnt8);
    end
    #2;
    reset8 = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (gnt8 !== 4'b0001 || id8 !== 2'd0) begin
      failures++;
      $display("FAIL mid_ptr_zero: got gnt=%b id=%0d want 0001/0", gnt8, id8);
    end
    req8 = 4'b0000;
    wait_release8(n);
  endtask

  // Behavioural model of the TIMEOUT=16 instance.
  logic [3:0] m_s1, m_s2, m_locked;
  int         m_owner, m_hold, m_ptr;
  logic       m_pulse;

  task automatic model_step(input logic [3:0] r);
    logic [3:0] rs;
    logic [3:0] nl;
    int         w;
    int         i;
    rs      = m_s2;
    m_pulse = 1'b0;
    nl      = m_locked & rs;
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (w < 0 && rs[i] && !m_locked[i]) w = i;
      end
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
      end
    end else if (!rs[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (m_hold == 16) begin
      nl[m_owner] = 1'b1;
      m_pulse     = 1'b1;
      m_ptr       = (m_owner + 1) % 4;
      m_owner     = -1;
    end else begin
      m_hold++;
    end
    m_locked = nl;
    m_s2     = m_s1;
    m_s1     = r;
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    logic [1:0] exp_id;
    logic [3:0] prev_g;
    logic [3:0] prev_lk;
    int         run;
    m_s1 = 4'b0000; m_s2 = 4'b0000; m_locked = 4'b0000;
    m_owner = -1; m_hold = 0; m_ptr = 0; m_pulse = 1'b0;
    prev_g = 4'b0000; prev_lk = 4'b0000; run = 0;
    @(negedge clk);
    req16 = 4'($urandom_range(0, 15));
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      model_step(req16);
      @(negedge clk);
      exp_g  = 4'b0000;
      exp_id = 2'd0;
      if (m_owner >= 0) begin
        exp_g[m_owner] = 1'b1;
        exp_id         = 2'(m_owner);
      end
      checks++;
      if (gnt16 !== exp_g || id16 !== exp_id || valid16 !== (m_owner >= 0) ||
          pulse16 !== m_pulse || locked16 !== m_locked) begin
        failures++;
        $display("FAIL rand_model c=%0d: got gnt=%b id=%0d v=%b p=%b lk=%b want gnt=%b id=%0d p=%b lk=%b",
                 c, gnt16, id16, valid16, pulse16, locked16, exp_g, exp_id, m_pulse, m_locked);
      end
      checks++;
      if ($countones(gnt16) > 1 || valid16 !== (|gnt16)) begin
        failures++;
        $display("FAIL rand_onehot c=%0d: got gnt=%b v=%b want one-hot/zero with v=|gnt", c, gnt16, valid16);
      end
      run = valid16 ? run + 1 : 0;
      checks++;
      if (run > 16) begin
        failures++;
        $display("FAIL rand_maxlen c=%0d: got run %0d want <=16", c, run);
      end
      checks++;
      if (gnt16 != 4'b0000 && prev_g == 4'b0000 && (gnt16 & prev_lk) != 4'b0000) begin
        failures++;
        $display("FAIL rand_locked_grant c=%0d: got gnt=%b with locked=%b want no overlap", c, gnt16, prev_lk);
      end
      prev_g  = gnt16;
      prev_lk = locked16;
      if (failures > 40) break;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 19) == 0) req16[b] = ~req16[b];
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_release_race();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
